// File: rtl/prog_loader_if.sv
// Byte-stream handshake between an image source and the program loader.
// The master drives bytes and the loader answers with in_ready.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words, writes them
// to consecutive RAM word addresses and holds the core in reset until the image is complete.
module prog_loader #(
  parameter int unsigned                ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0]    BASE_ADDR    = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  prog_loader_if.slave            s,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    core_hold,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESS_BITS-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDRESS_BITS-1:0] TOP_ADDR = ~(ADDRESS_BITS'(3));

  state_t                  state_q, state_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             shreg_q, shreg_d;
  logic                    last_q, last_d;
  logic [ADDRESS_BITS-1:0] address_q, address_d;
  logic [ADDRESS_BITS-1:0] word_count_q, word_count_d;

  logic                    in_ready_q, in_ready_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
  logic [31:0]             mem_write_data_q, mem_write_data_d;
  logic                    core_hold_q, core_hold_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    address_d    = address_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_RECV;
          address_d    = BASE_ADDR;
          byte_idx_d   = 2'd0;
          word_count_d = '0;
          shreg_d      = 32'h0000_0000;
          last_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RECV: begin
        if (s.in_valid) begin
          shreg_d[{byte_idx_q, 3'b000} +: 8] = s.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          last_d     = s.in_last;
          if ((byte_idx_q == 2'd3) || s.in_last) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + ADDRESS_BITS'(1);
        byte_idx_d   = 2'd0;
        shreg_d      = 32'h0000_0000;
        last_d       = 1'b0;
        // The top-of-space test comes before the increment so the address never wraps.
        if (last_q) begin
          state_d = S_DONE;
        end else if (address_q == TOP_ADDR) begin
          state_d = S_ERROR;
        end else begin
          address_d = address_q + ADDRESS_BITS'(4);
          state_d   = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    in_ready_d       = (state_d == S_RECV);
    mem_wen_d        = (state_d == S_WRITE);
    mem_address_d    = address_d;
    mem_write_data_d = (state_d == S_WRITE) ? shreg_d : 32'h0000_0000;
    core_hold_d      = (state_d != S_DONE);
    done_d           = (state_d == S_DONE);
    error_d          = (state_d == S_ERROR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      byte_idx_q       <= 2'd0;
      shreg_q          <= 32'h0000_0000;
      last_q           <= 1'b0;
      address_q        <= BASE_ADDR;
      word_count_q     <= '0;
      in_ready_q       <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_address_q    <= BASE_ADDR;
      mem_write_data_q <= 32'h0000_0000;
      core_hold_q      <= 1'b1;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      byte_idx_q       <= byte_idx_d;
      shreg_q          <= shreg_d;
      last_q           <= last_d;
      address_q        <= address_d;
      word_count_q     <= word_count_d;
      in_ready_q       <= in_ready_d;
      mem_wen_q        <= mem_wen_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      core_hold_q      <= core_hold_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

  assign s.in_ready     = in_ready_q;
  assign mem_wEn        = mem_wen_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign core_hold      = core_hold_q;
  assign done           = done_q;
  assign error          = error_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of byte images with expected RAM writes, plus hand-written
// sequences for reset mid-load, start collisions and address-space overflow.
module tb_prog_loader;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic start  = 1'b0;
  logic start4 = 1'b0;

  always #5 clock = ~clock;

  prog_loader_if s_if ();
  prog_loader_if s4_if ();

  logic        mem_wEn, core_hold, done, error;
  logic [15:0] mem_address, word_count;
  logic [31:0] mem_write_data;

  logic        mem_wEn4, core_hold4, done4, error4;
  logic [3:0]  mem_address4, word_count4;
  logic [31:0] mem_write_data4;

  prog_loader #(.ADDRESS_BITS(16), .BASE_ADDR(16'h0000)) dut (
    .clock(clock), .reset(reset), .start(start), .s(s_if),
    .mem_wEn(mem_wEn), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .core_hold(core_hold), .done(done), .error(error), .word_count(word_count)
  );

  prog_loader #(.ADDRESS_BITS(4), .BASE_ADDR(4'h0)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .s(s4_if),
    .mem_wEn(mem_wEn4), .mem_address(mem_address4), .mem_write_data(mem_write_data4),
    .core_hold(core_hold4), .done(done4), .error(error4), .word_count(word_count4)
  );

  typedef struct {
    int          n;
    logic [63:0] bytes;
    logic [63:0] words;
    int          wc;
    bit          gaps;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp4_q[$];
  logic prev_wen  = 1'b0;
  logic prev_wen4 = 1'b0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: every write pulse must match the oldest expected {address, data}.
  always @(negedge clock) begin
    if (mem_wEn === 1'b1) begin
      check("wen_single_cycle", {63'd0, prev_wen}, 64'd0);
      check("ready_low_in_write", {63'd0, s_if.in_ready}, 64'd0);
      if (exp_q.size() == 0) check("unexpected_write", {16'd0, mem_address, mem_write_data}, 64'd0);
      else check("write", {16'd0, mem_address, mem_write_data}, {16'd0, exp_q.pop_front()});
    end
    prev_wen = mem_wEn;
  end

  always @(negedge clock) begin
    if (mem_wEn4 === 1'b1) begin
      check("wen4_single_cycle", {63'd0, prev_wen4}, 64'd0);
      if (exp4_q.size() == 0) check("unexpected_write4", {28'd0, mem_address4, mem_write_data4}, 64'd0);
      else check("write4", {28'd0, mem_address4, mem_write_data4}, {16'd0, exp4_q.pop_front()});
    end
    prev_wen4 = mem_wEn4;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      s4_if.in_valid = v; s4_if.in_data = d; s4_if.in_last = l;
    end else begin
      s_if.in_valid = v; s_if.in_data = d; s_if.in_last = l;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? s4_if.in_ready : s_if.in_ready;
  endfunction

  // Offer one byte and hold it until the loader takes it.
  task automatic send(input bit sel, input logic [7:0] d, input logic l, input int gap);
    int b;
    repeat (gap) @(negedge clock);
    drive(sel, 1'b1, d, l);
    b = 0;
    while (rdy(sel) !== 1'b1 && b < 40) begin
      @(negedge clock);
      b++;
    end
    if (b >= 40) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", rdy(sel));
    end
    @(negedge clock);
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (done !== 1'b1 && b < 20) begin
      @(negedge clock);
      b++;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", {63'd0, s_if.in_ready}, 64'd0);
    check("rst_mem_wEn", {63'd0, mem_wEn}, 64'd0);
    check("rst_mem_address", {48'd0, mem_address}, 64'h0);
    check("rst_mem_write_data", {32'd0, mem_write_data}, 64'h0);
    check("rst_core_hold", {63'd0, core_hold}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_word_count", {48'd0, word_count}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic last;
    pulse_start();
    check("load_core_hold", {63'd0, core_hold}, 64'd1);
    check("load_done_clear", {63'd0, done}, 64'd0);
    check("load_in_ready", {63'd0, s_if.in_ready}, 64'd1);
    for (int i = 0; i < v.n; i++) begin
      last = (i == v.n - 1);
      if ((i % 4 == 3) || last)
        exp_q.push_back({16'(4 * (i / 4)), v.words[32 * (i / 4) +: 32]});
      send(1'b0, v.bytes[8 * i +: 8], last, v.gaps ? int'($urandom_range(0, 3)) : 0);
    end
    wait_done();
    check("end_done", {63'd0, done}, 64'd1);
    check("end_error", {63'd0, error}, 64'd0);
    check("end_core_hold", {63'd0, core_hold}, 64'd0);
    check("end_in_ready", {63'd0, s_if.in_ready}, 64'd0);
    check("end_word_count", {48'd0, word_count}, 64'(v.wc));
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{n: 8, bytes: 64'h0010_0093_0000_0013, words: 64'h0010_0093_0000_0013, wc: 2, gaps: 1'b0};
    vt[1] = '{n: 5, bytes: 64'h0000_00EE_DDCC_BBAA, words: 64'h0000_00EE_DDCC_BBAA, wc: 2, gaps: 1'b0};
    vt[2] = '{n: 8, bytes: 64'h0010_0093_0000_0013, words: 64'h0010_0093_0000_0013, wc: 2, gaps: 1'b1};
    vt[3] = '{n: 4, bytes: 64'h0000_0000_0403_0201, words: 64'h0000_0000_0403_0201, wc: 1, gaps: 1'b0};
    vt[4] = '{n: 7, bytes: 64'h0077_6655_4433_2211, words: 64'h0077_6655_4433_2211, wc: 2, gaps: 1'b1};

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    check_reset_vals();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_in_ready", {63'd0, s_if.in_ready}, 64'd0);
    check("idle_core_hold", {63'd0, core_hold}, 64'd1);

    for (int k = 0; k < 5; k++) run_vec(vt[k]);

    // Reset after six bytes: first word written, partial second word discarded.
    pulse_start();
    exp_q.push_back({16'h0000, 32'h0000_0013});
    send(1'b0, 8'h13, 1'b0, 0);
    send(1'b0, 8'h00, 1'b0, 0);
    send(1'b0, 8'h00, 1'b0, 0);
    send(1'b0, 8'h00, 1'b0, 0);
    send(1'b0, 8'h93, 1'b0, 0);
    send(1'b0, 8'h00, 1'b0, 0);
    reset = 1'b0;
    #1;
    check_reset_vals();
    check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // start and in_valid together in IDLE: the byte must not be taken.
    start = 1'b1;
    drive(1'b0, 1'b1, 8'hFF, 1'b1);
    @(negedge clock);
    start = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("collide_in_ready", {63'd0, s_if.in_ready}, 64'd1);
    repeat (3) @(negedge clock);
    check("collide_word_count", {48'd0, word_count}, 64'd0);
    exp_q.push_back({16'h0000, 32'h0000_005A});
    send(1'b0, 8'h5A, 1'b1, 0);
    wait_done();
    check("collide_done", {63'd0, done}, 64'd1);
    check("collide_word_count_end", {48'd0, word_count}, 64'd1);

    run_vec(vt[0]);

    // Overflow on a 16-byte space; a start pulse mid-load must be ignored.
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
      end
      if (i % 4 == 3)
        exp4_q.push_back({16'(4 * (i / 4)), 8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)});
      send(1'b1, 8'(i + 1), 1'b0, 0);
    end
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    repeat (4) @(negedge clock);
    check("ovf_in_ready", {63'd0, s4_if.in_ready}, 64'd0);
    check("ovf_error", {63'd0, error4}, 64'd1);
    check("ovf_core_hold", {63'd0, core_hold4}, 64'd1);
    check("ovf_done", {63'd0, done4}, 64'd0);
    check("ovf_word_count", {60'd0, word_count4}, 64'd4);
    check("ovf_queue_empty", 64'(exp4_q.size()), 64'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);

    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    check("ovf_restart_error", {63'd0, error4}, 64'd0);
    check("ovf_restart_ready", {63'd0, s4_if.in_ready}, 64'd1);
    exp4_q.push_back({16'h0000, 32'h0000_00A5});
    send(1'b1, 8'hA5, 1'b1, 0);
    repeat (3) @(negedge clock);
    check("ovf_restart_done", {63'd0, done4}, 64'd1);
    check("ovf_restart_wc", {60'd0, word_count4}, 64'd1);
    check("ovf_restart_queue", 64'(exp4_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
